// File: rtl/e1_led_sched.sv
// e1_led_sched: periodic LED frame scheduler for the shared shift-register /
// button-sense interface. It issues one LED frame per refresh tick and turns the
// per-frame button samples into a debounced level, press pulses and long-press pulses.
module e1_led_sched #(
  parameter int REFRESH_LOG2 = 16,
  parameter int LONG_PRESS   = 24
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_led_mode,
  input  logic        i_led_en,
  output logic [7:0]  o_sr_val,
  output logic        o_sr_go,
  input  logic        i_sr_rdy,
  input  logic        i_btn_val,
  input  logic        i_btn_stb,
  output logic        o_btn_state,
  output logic        o_btn_press,
  output logic        o_btn_long,
  output logic        o_frame_ovr
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  localparam logic [REFRESH_LOG2-1:0] TMR_ONE = REFRESH_LOG2'(1);
  localparam logic [7:0]              LP8     = 8'(LONG_PRESS);

  state_t                  r_state;
  logic [REFRESH_LOG2-1:0] r_tmr;
  logic                    r_pend;
  logic                    r_ovr;
  logic [7:0]              r_frame_cnt;
  logic [7:0]              r_sr_val;
  logic                    r_sr_go;
  logic                    r_last;
  logic                    r_btn_state;
  logic                    r_btn_press;
  logic                    r_btn_long;
  logic [7:0]              r_hold;

  logic       w_wrap;
  logic       w_acc;
  logic [7:0] w_frame;
  logic       w_btn_chg;
  logic       w_btn_next;
  logic [7:0] w_hold_inc;

  assign w_wrap     = &r_tmr;
  assign w_acc      = (r_state == ST_ISSUE) & r_sr_go & i_sr_rdy;
  assign w_btn_chg  = i_btn_stb & (i_btn_val == r_last) & (i_btn_val != r_btn_state);
  assign w_btn_next = w_btn_chg ? i_btn_val : r_btn_state;
  assign w_hold_inc = r_hold + 8'd1;

  // Compose the LED frame from the per-LED modes and the current blink phase.
  always_comb begin
    w_frame = '0;
    for (int i = 0; i < 8; i++) begin
      case (i_led_mode[2*i +: 2])
        2'b01:   w_frame[i] = 1'b1;
        2'b10:   w_frame[i] = r_frame_cnt[7];
        2'b11:   w_frame[i] = r_frame_cnt[5];
        default: w_frame[i] = 1'b0;
      endcase
    end
    if (!i_led_en) w_frame = '0;
  end

  // Free-running refresh timer; its wrap is the refresh tick.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_tmr <= '0;
    else          r_tmr <= r_tmr + TMR_ONE;
  end

  // Pending-frame flag and sticky overrun: a tick landing while a frame is
  // already pending or in flight merges into the single pending request.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pend <= 1'b1;
      r_ovr  <= 1'b0;
    end else begin
      r_pend <= w_wrap | (r_pend & ~w_acc);
      if (w_wrap & (r_pend | (r_state != ST_IDLE))) r_ovr <= 1'b1;
    end
  end

  // Frame issue FSM: IDLE latches the frame, ISSUE holds it until accepted,
  // WAIT lets the shift cycle finish (signalled by the button strobe).
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_sr_go     <= 1'b0;
      r_sr_val    <= '0;
      r_frame_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_pend) begin
            r_sr_val <= w_frame;
            r_sr_go  <= 1'b1;
            r_state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (w_acc) begin
            r_sr_go     <= 1'b0;
            r_frame_cnt <= r_frame_cnt + 8'd1;
            r_state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (i_btn_stb) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Button debounce (two equal samples), press / long-press pulses, hold count.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_last      <= 1'b0;
      r_btn_state <= 1'b0;
      r_btn_press <= 1'b0;
      r_btn_long  <= 1'b0;
      r_hold      <= '0;
    end else begin
      r_btn_press <= 1'b0;
      r_btn_long  <= 1'b0;
      if (i_btn_stb) begin
        r_last      <= i_btn_val;
        r_btn_state <= w_btn_next;
        if (w_btn_chg & i_btn_val) r_btn_press <= 1'b1;
        if (w_btn_next) begin
          if (r_hold != 8'hFF) begin
            r_hold <= w_hold_inc;
            if (w_hold_inc == LP8) r_btn_long <= 1'b1;
          end
        end else begin
          r_hold <= '0;
        end
      end
    end
  end

  assign o_sr_val    = r_sr_val;
  assign o_sr_go     = r_sr_go;
  assign o_btn_state = r_btn_state;
  assign o_btn_press = r_btn_press;
  assign o_btn_long  = r_btn_long;
  assign o_frame_ovr = r_ovr;

endmodule

// File: tb/tb_e1_led_sched.sv
// Bench for e1_led_sched: directed scenarios plus a randomized run, all checked
// every cycle against a behavioural model of the scheduler and button logic.
module tb_e1_led_sched;

  localparam int RL2 = 4;
  localparam int P   = 1 << RL2;
  localparam int LP  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] led_mode = '0;
  logic        led_en = 1'b0;
  logic        sr_rdy = 1'b0;
  logic        btn_val = 1'b0;
  logic        btn_stb = 1'b0;
  logic [7:0]  sr_val;
  logic        sr_go, btn_state, btn_press, btn_long, frame_ovr;

  always #5 clk = ~clk;

  e1_led_sched #(.REFRESH_LOG2(RL2), .LONG_PRESS(LP)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_led_mode(led_mode), .i_led_en(led_en),
    .o_sr_val(sr_val), .o_sr_go(sr_go), .i_sr_rdy(sr_rdy),
    .i_btn_val(btn_val), .i_btn_stb(btn_stb),
    .o_btn_state(btn_state), .o_btn_press(btn_press), .o_btn_long(btn_long),
    .o_frame_ovr(frame_ovr)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  int         m_t, m_frames, m_hold;
  bit         m_pend, m_go, m_wait, m_ovr, m_last, m_state, m_press, m_long;
  bit         m_tick, m_acc, m_idle;
  logic [7:0] m_val;

  function automatic logic [7:0] compose(input logic [15:0] mode, input logic en, input int f);
    logic [7:0] v;
    bit slow, fast;
    int md;
    slow = ((f / 128) % 2) == 1;
    fast = ((f / 32) % 2) == 1;
    for (int i = 0; i < 8; i++) begin
      md = int'(mode[2*i +: 2]);
      v[i] = en && (md == 1 || (md == 2 && slow) || (md == 3 && fast));
    end
    return v;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_t = 0; m_pend = 1; m_go = 0; m_wait = 0; m_frames = 0; m_val = '0; m_ovr = 0;
      m_last = 0; m_state = 0; m_hold = 0; m_press = 0; m_long = 0;
    end else begin
      m_tick = (m_t % P) == P - 1;
      m_t++;
      m_acc  = m_go && sr_rdy;
      m_idle = !m_go && !m_wait;
      if (m_tick && (m_pend || !m_idle)) m_ovr = 1;
      if (m_idle && m_pend) begin
        m_go = 1; m_val = compose(led_mode, led_en, m_frames);
      end else if (m_acc) begin
        m_go = 0; m_wait = 1; m_frames++;
      end else if (m_wait && btn_stb) begin
        m_wait = 0;
      end
      m_pend = (m_pend && !m_acc) || m_tick;
      m_press = 0; m_long = 0;
      if (btn_stb) begin
        if (btn_val == m_last && btn_val != m_state) begin
          m_state = btn_val;
          if (btn_val) m_press = 1;
        end
        m_last = btn_val;
        if (!m_state) m_hold = 0;
        else if (m_hold < 255) begin
          m_hold++;
          if (m_hold == LP) m_long = 1;
        end
      end
    end
  end

  bit cmp_en = 0;

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en)
      chk("cycle_outputs",
          int'({sr_go, sr_val, btn_state, btn_press, btn_long, frame_ovr}),
          int'({m_go, m_val, m_state, m_press, m_long, m_ovr}));
  end

  // ---------------- stimulus / interface responder ----------------
  int         nf;
  logic [7:0] seen [0:511];
  int         stb_cnt = 0;
  int         stb_dly = 3;
  bit         auto_stb = 1, rdy_rand = 0, rnd_stb = 0, rnd_btn = 0;

  task automatic step();
    if (sr_go && sr_rdy) begin
      if (nf < 512) seen[nf] = sr_val;
      nf++;
      stb_cnt = stb_dly;
    end
    @(negedge clk);
    btn_stb = 1'b0;
    if (stb_cnt > 0) begin
      stb_cnt--;
      if (stb_cnt == 0 && auto_stb) btn_stb = 1'b1;
    end
    if (rnd_stb && $urandom_range(0, 11) == 0) btn_stb = 1'b1;
    if (rnd_btn && btn_stb && $urandom_range(0, 3) == 0) btn_val = ~btn_val;
    if (rdy_rand) sr_rdy = ($urandom_range(0, 3) != 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; btn_stb = 1'b0; stb_cnt = 0;
    repeat (3) @(negedge clk);
    nf = 0; rst_n = 1'b1;
  endtask

  task automatic strobe(input logic v);
    btn_val = v; btn_stb = 1'b1;
    step();
  endtask

  logic [7:0] v0;
  int         stable, n0, nz, np, nl, p1, p2, l1, l2, st11, st12;
  logic [5:0] seq5 = 6'b111010;
  logic       v;

  initial begin
    // 1: first frame straight out of reset
    led_mode = 16'h0001; led_en = 1'b1; sr_rdy = 1'b1;
    do_reset();
    cmp_en = 1;
    step();
    chk("t1_go_cycle1", int'(sr_go), 1);
    chk("t1_val_cycle1", int'(sr_val), 8'h01);
    step();
    chk("t1_go_cycle2", int'(sr_go), 0);
    chk("t1_frames", nf, 1);
    chk("t1_model_frames", m_frames, 1);

    // 2: back-pressure holds the frame steady
    sr_rdy = 1'b0;
    do_reset();
    step();
    chk("t2_go_rise", int'(sr_go), 1);
    v0 = sr_val;
    chk("t2_val", int'(v0), 8'h01);
    stable = 1;
    for (int i = 0; i < 9; i++) begin
      step();
      if (!(sr_go && sr_val == v0)) stable = 0;
    end
    chk("t2_stable", stable, 1);
    chk("t2_no_xfer", nf, 0);
    sr_rdy = 1'b1;
    step();
    chk("t2_go_drop", int'(sr_go), 0);
    chk("t2_one_frame", nf, 1);

    // 3: blink phases and blanking
    led_mode = 16'hFFAA;
    do_reset();
    for (int c = 0; c < 6000 && nf < 260; c++) step();
    chk("t3_frame_count", int'(nf >= 260), 1);
    chk("t3_f0", int'(seen[0]), 8'h00);
    chk("t3_f31", int'(seen[31]), 8'h00);
    chk("t3_f32", int'(seen[32]), 8'hF0);
    chk("t3_f64", int'(seen[64]), 8'h00);
    chk("t3_f128", int'(seen[128]), 8'h0F);
    chk("t3_f160", int'(seen[160]), 8'hFF);
    chk("t3_f256", int'(seen[256]), 8'h00);
    led_en = 1'b0;
    n0 = nf;
    for (int c = 0; c < 1000 && nf < n0 + 20; c++) step();
    chk("t3_frames_continue", int'(nf >= n0 + 20), 1);
    nz = 0;
    for (int k = n0 + 2; k < n0 + 20; k++) if (seen[k] != 8'h00) nz++;
    chk("t3_blank_frames", nz, 0);

    // 4: strobe withheld -> ticks coalesce, overrun sticks
    led_mode = 16'h5555; led_en = 1'b1; sr_rdy = 1'b1; auto_stb = 0;
    do_reset();
    for (int c = 0; c < 20 && nf < 1; c++) step();
    chk("t4_first_frame", nf, 1);
    repeat (40) step();
    chk("t4_stalled", nf, 1);
    chk("t4_ovr_set", int'(frame_ovr), 1);
    chk("t4_model_ovr", int'(m_ovr), 1);
    btn_val = 1'b0; btn_stb = 1'b1;
    repeat (40) step();
    chk("t4_one_more", nf, 2);
    chk("t4_ovr_sticky", int'(frame_ovr), 1);

    // 5: debounce rejects an isolated sample
    do_reset();
    np = 0; p1 = 0;
    for (int k = 0; k < 6; k++) begin
      strobe(seq5[k]);
      if (btn_press) begin np++; p1 = k + 1; end
      step(); step();
    end
    chk("t5_press_count", np, 1);
    chk("t5_press_at", p1, 5);
    chk("t5_state", int'(btn_state), 1);

    // 6: long press, release, fresh long press
    do_reset();
    np = 0; nl = 0; p1 = 0; p2 = 0; l1 = 0; l2 = 0; st11 = 0; st12 = 0;
    for (int k = 0; k < 18; k++) begin
      v = (k < 10) || (k >= 12);
      strobe(v);
      if (btn_press) begin np++; if (np == 1) p1 = k + 1; else p2 = k + 1; end
      if (btn_long)  begin nl++; if (nl == 1) l1 = k + 1; else l2 = k + 1; end
      if (k == 10) st11 = int'(btn_state);
      if (k == 11) st12 = int'(btn_state);
      step();
    end
    chk("t6_press_count", np, 2);
    chk("t6_press1_at", p1, 2);
    chk("t6_press2_at", p2, 14);
    chk("t6_long_count", nl, 2);
    chk("t6_long1_at", l1, 5);
    chk("t6_long2_at", l2, 17);
    chk("t6_state_after_one_zero", st11, 1);
    chk("t6_state_after_two_zeros", st12, 0);

    // Randomized run, including a reset mid-stream
    auto_stb = 1; rdy_rand = 1; rnd_stb = 1; rnd_btn = 1;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      if ($urandom_range(0, 63) == 0) led_mode = 16'($urandom);
      if ($urandom_range(0, 63) == 0) led_en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 31) == 0) stb_dly = $urandom_range(1, 5);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/e1_led_sched.md
# e1_led_sched

Periodic scheduler for the shared LED shift-register / button-sense interface of the icE1usb. It owns the `sr_val` / `sr_go` / `sr_rdy` handshake. Each refresh it composes an 8-bit LED frame from per-LED modes (off / on / slow blink / fast blink) and issues it. It also turns the per-frame `btn_val` / `btn_stb` samples into debounced press and long-press events. Frames never stop, even when LEDs are blanked, because button sensing only happens during a shift cycle.

## Interface

Parameters:
- `REFRESH_LOG2`, default 16: refresh period is 2^REFRESH_LOG2 clk cycles.
- `LONG_PRESS`, default 24: number of consecutive pressed samples that raise `btn_long`. Range 2..255.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `led_mode`, in, 16: 2 bits per LED; LED i uses `[2i+1:2i]`. 00 = off, 01 = on, 10 = slow blink, 11 = fast blink.
- `led_en`, in, 1: 0 forces an all-zero frame. Frames are still issued.
- `sr_val`, out, 8: frame to the shift-register interface. Bit i is LED i.
- `sr_go`, out, 1: frame request. Held until accepted.
- `sr_rdy`, in, 1: interface idle. Transfer happens on `sr_go & sr_rdy`.
- `btn_val`, in, 1: button sample, 1 = pressed. Valid with `btn_stb`.
- `btn_stb`, in, 1: one-cycle strobe at the end of each shift cycle.
- `btn_state`, out, 1: debounced button level.
- `btn_press`, out, 1: one-cycle pulse on a debounced 0→1 transition.
- `btn_long`, out, 1: one-cycle pulse when a press reaches `LONG_PRESS` samples.
- `frame_ovr`, out, 1: sticky flag. Set when a refresh tick is coalesced. Cleared only by reset.

## Operation

Refresh timer:
- Free-running counter of `REFRESH_LOG2` bits.
- On wrap it sets `pend`.
- `pend` is cleared when a frame is accepted.
- If `pend` is already set, or the FSM is not in IDLE, when the timer wraps, the tick is coalesced (no queueing) and `frame_ovr` is set.
- `pend` is 1 out of reset, so the first frame goes out immediately.

Blink phase:
- `frame_cnt` is 8 bits, increments on each accepted frame, and wraps freely.
- Slow phase = `frame_cnt[7]`; fast phase = `frame_cnt[5]`.
- The phase used for a frame is the `frame_cnt` value before the increment.

Frame composition, for each bit i:
- `sr_val[i]` = `led_en & (mode==01 | (mode==10 & slow) | (mode==11 & fast))`.
- Composed and registered on the IDLE→ISSUE transition.
- Held constant while `sr_go` = 1.

FSM:
- IDLE: when `pend` = 1, register the frame, set `sr_go`, go to ISSUE.
- ISSUE: stay while `sr_go` = 1 and `sr_rdy` = 0. On `sr_go & sr_rdy`, in the same cycle: clear `pend`, increment `frame_cnt`, and register `sr_go` ← 0. Next state is WAIT.
- WAIT: on `btn_stb`, go to IDLE. `pend` is evaluated again only in IDLE.
- `btn_stb` arriving while in IDLE or ISSUE is still processed by the button logic; it does not move the FSM.

Button logic (acts on `btn_stb` only):
- Sample register `last`; debounced level `btn_state`; hold counter `hold`, 8 bits, saturating at 255.
- On each strobe: `last` ← `btn_val`.
- If `btn_val == last` and `btn_val != btn_state`, then `btn_state` ← `btn_val`. So a change needs 2 consecutive equal samples.
- A 0→1 change of `btn_state` pulses `btn_press`.
- While the new `btn_state` = 1, `hold` increments on each strobe.
- `btn_long` pulses on the strobe where `hold` becomes exactly `LONG_PRESS`, so at most once per press.
- A debounced release clears `hold` to 0.

Reset values:
- FSM = IDLE; `pend` = 1; all counters = 0; `last` = 0.
- `sr_go`, `sr_val`, `btn_state`, `btn_press`, `btn_long`, `frame_ovr` = 0.
- Reset mid-ISSUE drops `sr_go` on the next edge. The interrupted frame is abandoned and not retried, beyond the `pend` = 1 reset value.

## Timing

- `sr_go` rises 1 cycle after `pend` is seen in IDLE.
- The transfer cycle is the first cycle with `sr_go & sr_rdy`. `sr_go` is 0 in the following cycle.
- `btn_press`, `btn_long` and `btn_state` update 1 cycle after the qualifying `btn_stb`.
- `sr_go` and `btn_press` never assert for more than one cycle per event.
- Only `sr_val`, `sr_go`, `btn_state`, `btn_press`, `btn_long` and `frame_ovr` are outputs, and all of them are registered.

## Test plan

1. Reset release, `sr_rdy` = 1, `led_mode` = 0x0001, `led_en` = 1 → `sr_go` high in cycle 1 with `sr_val` = 0x01. `sr_go` is low in cycle 2. `frame_cnt` = 1.
2. `REFRESH_LOG2` = 6, `sr_rdy` held 0 for 10 cycles after `sr_go` → `sr_go` and `sr_val` are stable for all 10 cycles, the transfer happens on the first `sr_rdy` = 1, and exactly one frame is counted.
3. `led_mode` = 0xFFAA (LEDs 0–3 slow, 4–7 fast), `REFRESH_LOG2` = 4, with a strobe model returning `btn_stb` 3 cycles after accept → bits 4–7 toggle every 32 frames and bits 0–3 every 128 frames. `led_en` = 0 gives `sr_val` = 0x00 while frames continue.
4. Model holds `btn_stb` off for 40 cycles with `REFRESH_LOG2` = 4 → exactly one frame is issued after `btn_stb`, and `frame_ovr` becomes 1 and stays 1.
5. `btn_val` sequence 0,1,0,1,1,1 on successive strobes → one `btn_press`, 1 cycle after the 5th strobe. No press occurs on the isolated 1 at strobe 2.
6. `LONG_PRESS` = 4; `btn_val` held at 1 for 10 strobes, then 0,0 → one `btn_press`, then one `btn_long` at the 4th sample after the debounced press. `btn_state` returns to 0 after the second 0, then a fresh press yields a new `btn_long`.
